// File: rtl/canvas_draw_scheduler.sv
// Arbitrates cell paint and canvas clear requests onto the single framebuffer
// write port and keeps the one-bit-per-cell occupancy bitmap.
module canvas_draw_scheduler #(
    parameter int          X0     = 88,
    parameter int          Y0     = 37,
    parameter int          CELL_W = 10,
    parameter int          CELL_H = 14,
    parameter int          COLS   = 14,
    parameter int          ROWS   = 13,
    parameter logic [14:0] FG     = 15'h7FFF,
    parameter logic [14:0] BG     = 15'h0000
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 paint_req,
    input  logic [3:0]           paint_col,
    input  logic [3:0]           paint_row,
    input  logic                 paint_val,
    output logic                 paint_ack,
    input  logic                 clear_req,
    output logic                 clear_ack,
    output logic                 busy,
    output logic [8:0]           x,
    output logic [8:0]           y,
    output logic [14:0]          colour,
    output logic                 plot,
    output logic [COLS*ROWS-1:0] cells
);

    localparam int SPAN_X = COLS * CELL_W;
    localparam int SPAN_Y = ROWS * CELL_H;
    localparam int NCELL  = COLS * ROWS;
    localparam int XW     = $clog2(SPAN_X);
    localparam int YW     = $clog2(SPAN_Y);
    localparam int IW     = $clog2(NCELL);

    typedef enum logic [1:0] {IDLE, PAINT, CLEAR, ACK} state_t;

    state_t          state;
    state_t          state_nx;

    logic [XW-1:0]   cnt_x;
    logic [XW-1:0]   lim_x;
    logic [YW-1:0]   cnt_y;
    logic [YW-1:0]   lim_y;
    logic [8:0]      base_x;
    logic [8:0]      base_y;
    logic [14:0]     fill;
    logic            done;
    logic            wr_en;
    logic            wr_val;
    logic [IW-1:0]   wr_idx;

    logic            req_ok;
    logic            req_cur;
    logic            req_skip;
    logic [IW-1:0]   req_idx;

    logic            emit;
    logic            plot_d;
    logic            paint_ack_d;
    logic            clear_ack_d;
    logic [8:0]      x_d;
    logic [8:0]      y_d;
    logic [14:0]     colour_d;

    assign req_ok   = (int'(paint_col) < COLS) && (int'(paint_row) < ROWS);
    assign req_idx  = IW'(int'(paint_row) * COLS + int'(paint_col));
    assign req_cur  = req_ok & cells[req_idx];
    // Rewriting a cell with its current value is dropped without touching the framebuffer
    assign req_skip = !req_ok || (paint_val == req_cur);

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nx = CLEAR;
                end else if (paint_req) begin
                    state_nx = PAINT;
                end
            end
            PAINT, CLEAR: begin
                if (done) begin
                    state_nx = ACK;
                end
            end
            ACK: state_nx = IDLE;
        endcase
    end

    always_comb begin
        emit        = ((state == PAINT) || (state == CLEAR)) && !done;
        plot_d      = emit;
        x_d         = emit ? base_x + 9'(cnt_x) : x;
        y_d         = emit ? base_y + 9'(cnt_y) : y;
        colour_d    = emit ? fill : colour;
        paint_ack_d = (state == PAINT) && done;
        clear_ack_d = (state == CLEAR) && done;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x         <= 9'(X0);
            y         <= 9'(Y0);
            colour    <= BG;
            plot      <= 1'b0;
            paint_ack <= 1'b0;
            clear_ack <= 1'b0;
            cells     <= '0;
            cnt_x     <= '0;
            cnt_y     <= '0;
            lim_x     <= XW'(SPAN_X - 1);
            lim_y     <= YW'(SPAN_Y - 1);
            base_x    <= 9'(X0);
            base_y    <= 9'(Y0);
            fill      <= BG;
            done      <= 1'b0;
            wr_en     <= 1'b0;
            wr_val    <= 1'b0;
            wr_idx    <= '0;
        end else begin
            x         <= x_d;
            y         <= y_d;
            colour    <= colour_d;
            plot      <= plot_d;
            paint_ack <= paint_ack_d;
            clear_ack <= clear_ack_d;
            if (state == IDLE) begin
                cnt_x <= '0;
                cnt_y <= '0;
                done  <= 1'b0;
                if (clear_req) begin
                    base_x <= 9'(X0);
                    base_y <= 9'(Y0);
                    lim_x  <= XW'(SPAN_X - 1);
                    lim_y  <= YW'(SPAN_Y - 1);
                    fill   <= BG;
                    wr_en  <= 1'b0;
                end else if (paint_req) begin
                    base_x <= 9'(X0) + 9'(paint_col) * 9'(CELL_W);
                    base_y <= 9'(Y0) + 9'(paint_row) * 9'(CELL_H);
                    lim_x  <= XW'(CELL_W - 1);
                    lim_y  <= YW'(CELL_H - 1);
                    fill   <= paint_val ? FG : BG;
                    done   <= req_skip;
                    wr_en  <= !req_skip;
                    wr_val <= paint_val;
                    wr_idx <= req_idx;
                end
            end else if (emit) begin
                if (cnt_x == lim_x) begin
                    cnt_x <= '0;
                    if (cnt_y == lim_y) begin
                        done <= 1'b1;
                    end else begin
                        cnt_y <= cnt_y + YW'(1);
                    end
                end else begin
                    cnt_x <= cnt_x + XW'(1);
                end
            end
            if (paint_ack_d && wr_en) begin
                cells[wr_idx] <= wr_val;
            end
            if (clear_ack_d) begin
                cells <= '0;
            end
        end
    end

endmodule

// File: tb/tb_canvas_draw_scheduler.sv
// Bench for canvas_draw_scheduler: directed and random paints, clears,
// arbitration and reset abort, checked against a pixel-list model.
`timescale 1ns/1ps
module tb_canvas_draw_scheduler;

    localparam int          X0   = 88;
    localparam int          Y0   = 37;
    localparam int          CW   = 10;
    localparam int          CH   = 14;
    localparam int          COLS = 14;
    localparam int          ROWS = 13;
    localparam int          NC   = COLS * ROWS;
    localparam logic [14:0] FG   = 15'h7FFF;
    localparam logic [14:0] BG   = 15'h0000;

    typedef struct {
        int x;
        int y;
        int c;
        int t;
    } pix_t;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          paint_req = 1'b0;
    logic [3:0]    paint_col = '0;
    logic [3:0]    paint_row = '0;
    logic          paint_val = 1'b0;
    logic          clear_req = 1'b0;
    logic          paint_ack;
    logic          clear_ack;
    logic          busy;
    logic [8:0]    x;
    logic [8:0]    y;
    logic [14:0]   colour;
    logic          plot;
    logic [NC-1:0] cells;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            viol = 0;
    pix_t          pq[$];
    pix_t          cq[$];
    pix_t          eq[$];
    pix_t          mp;
    int            pa_q[$];
    int            ca_q[$];
    logic [NC-1:0] mcells = '0;

    canvas_draw_scheduler dut (
        .clock     (clock),
        .resetn    (resetn),
        .paint_req (paint_req),
        .paint_col (paint_col),
        .paint_row (paint_row),
        .paint_val (paint_val),
        .paint_ack (paint_ack),
        .clear_req (clear_req),
        .clear_ack (clear_ack),
        .busy      (busy),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .cells     (cells)
    );

    always #10 clock = ~clock;

    // Records every write and ack, stamped with the index of the edge that produced it
    always @(posedge clock) begin
        cyc++;
        #2;
        if (plot === 1'b1) begin
            mp.x = int'(x);
            mp.y = int'(y);
            mp.c = int'(colour);
            mp.t = cyc;
            pq.push_back(mp);
            if (busy !== 1'b1) viol++;
            if (paint_ack === 1'b1 || clear_ack === 1'b1) viol++;
        end
        if (paint_ack === 1'b1) pa_q.push_back(cyc);
        if (clear_ack === 1'b1) ca_q.push_back(cyc);
    end

    function automatic void build_clear();
        pix_t p;
        cq.delete();
        for (int yy = 0; yy < ROWS * CH; yy++) begin
            for (int xx = 0; xx < COLS * CW; xx++) begin
                p.x = X0 + xx;
                p.y = Y0 + yy;
                p.c = int'(BG);
                p.t = 0;
                cq.push_back(p);
            end
        end
    endfunction

    function automatic void exp_paint(input int c, input int r, input int v);
        pix_t p;
        eq.delete();
        if (c >= COLS || r >= ROWS) return;
        if (int'(mcells[r*COLS+c]) == v) return;
        for (int yy = 0; yy < CH; yy++) begin
            for (int xx = 0; xx < CW; xx++) begin
                p.x = X0 + c * CW + xx;
                p.y = Y0 + r * CH + yy;
                p.c = (v != 0) ? int'(FG) : int'(BG);
                p.t = 0;
                eq.push_back(p);
            end
        end
    endfunction

    task automatic issue_paint(input int c, input int r, input int v,
                               output int t, output int a);
        pq.delete();
        pa_q.delete();
        paint_col = 4'(c);
        paint_row = 4'(r);
        paint_val = v[0];
        paint_req = 1'b1;
        t = cyc + 1;
        for (int k = 0; k < 400 && pa_q.size() == 0; k++) @(negedge clock);
        a = (pa_q.size() > 0) ? pa_q[0] : -1;
        paint_req = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        int t;
        int bad;
        int ca0;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        tests++;
        if (plot !== 1'b0 || paint_ack !== 1'b0 || clear_ack !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: plot=%b pa=%b ca=%b, need 0 0 0",
                     plot, paint_ack, clear_ack);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_busy: got %b, need 1", busy);
        end
        tests++;
        if (x !== 9'(X0) || y !== 9'(Y0) || colour !== BG) begin
            fails++;
            $display("FAIL reset_xy: got %0d,%0d,%h need %0d,%0d,%h",
                     x, y, colour, X0, Y0, BG);
        end
        tests++;
        if (cells !== '0) begin
            fails++;
            $display("FAIL reset_cells: got %h, need 0", cells);
        end
        pq.delete();
        ca_q.delete();
        pa_q.delete();
        t = cyc;
        resetn = 1'b1;
        for (int k = 0; k < 26000 && ca_q.size() == 0; k++) @(negedge clock);
        ca0 = (ca_q.size() > 0) ? ca_q[0] : -1;
        tests++;
        if (ca0 != t + 1 + cq.size()) begin
            fails++;
            $display("FAIL autoclear_ack: got cycle %0d, need %0d", ca0, t + 1 + cq.size());
        end
        tests++;
        if (pq.size() != cq.size()) begin
            fails++;
            $display("FAIL autoclear_count: got %0d plots, need %0d", pq.size(), cq.size());
        end
        bad = -1;
        for (int j = 0; j < cq.size(); j++) begin
            if (j >= pq.size() || pq[j].x != cq[j].x || pq[j].y != cq[j].y ||
                pq[j].c != cq[j].c || pq[j].t != t + 1 + j) begin
                bad = j;
                break;
            end
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL autoclear_scan: pixel %0d wrong, need (%0d,%0d) at %0d",
                     bad, cq[bad].x, cq[bad].y, t + 1 + bad);
        end
        tests++;
        if (cells !== '0) begin
            fails++;
            $display("FAIL autoclear_cells: got %h, need 0", cells);
        end
        @(negedge clock);
        tests++;
        if (busy !== 1'b0 || ca_q.size() != 1) begin
            fails++;
            $display("FAIL autoclear_idle: busy=%b acks=%0d, need 0 and 1", busy, ca_q.size());
        end
    endtask

    task automatic test_paint();
        int oc[$];
        int orow[$];
        int ov[$];
        int t;
        int a;
        int bad;
        oc.push_back(3); orow.push_back(2); ov.push_back(1);
        oc.push_back(3); orow.push_back(2); ov.push_back(1);
        oc.push_back(3); orow.push_back(2); ov.push_back(0);
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 2) begin
                oc.push_back(oc[$]);
                orow.push_back(orow[$]);
                ov.push_back(ov[$]);
            end else begin
                oc.push_back(int'($urandom_range(0, COLS - 1)));
                orow.push_back(int'($urandom_range(0, ROWS - 1)));
                ov.push_back(int'($urandom_range(0, 1)));
            end
        end
        for (int i = 0; i < oc.size(); i++) begin
            exp_paint(oc[i], orow[i], ov[i]);
            issue_paint(oc[i], orow[i], ov[i], t, a);
            tests++;
            if (a != t + 1 + eq.size()) begin
                fails++;
                $display("FAIL paint_ack op%0d: got cycle %0d, need %0d", i, a, t + 1 + eq.size());
            end
            tests++;
            if (pq.size() != eq.size()) begin
                fails++;
                $display("FAIL paint_count op%0d: got %0d plots, need %0d", i, pq.size(), eq.size());
            end
            bad = -1;
            for (int j = 0; j < eq.size(); j++) begin
                if (j >= pq.size() || pq[j].x != eq[j].x || pq[j].y != eq[j].y ||
                    pq[j].c != eq[j].c || pq[j].t != t + 1 + j) begin
                    bad = j;
                    break;
                end
            end
            tests++;
            if (bad >= 0) begin
                fails++;
                $display("FAIL paint_scan op%0d: pixel %0d wrong, need (%0d,%0d,%h)",
                         i, bad, eq[bad].x, eq[bad].y, eq[bad].c);
            end
            if (eq.size() > 0) mcells[orow[i]*COLS+oc[i]] = ov[i][0];
            tests++;
            if (cells !== mcells) begin
                fails++;
                $display("FAIL paint_cells op%0d: got %h, need %h", i, cells, mcells);
            end
        end
    endtask

    task automatic test_invalid();
        int ic[3] = '{14, 3, 15};
        int ir[3] = '{0, 13, 15};
        int t;
        int a;
        for (int i = 0; i < 3; i++) begin
            issue_paint(ic[i], ir[i], 1, t, a);
            tests++;
            if (a != t + 1 || pq.size() != 0 || cells !== mcells) begin
                fails++;
                $display("FAIL invalid%0d: ack %0d plots %0d cells %h, need ack %0d plots 0 cells %h",
                         i, a, pq.size(), cells, t + 1, mcells);
            end
        end
    endtask

    task automatic test_priority();
        int t;
        int n0;
        int bad;
        int ca0;
        int pa0;
        pq.delete();
        ca_q.delete();
        pa_q.delete();
        t = cyc + 1;
        clear_req = 1'b1;
        paint_col = 4'd0;
        paint_row = 4'd0;
        paint_val = 1'b1;
        paint_req = 1'b1;
        for (int k = 0; k < 26000 && ca_q.size() == 0; k++) @(negedge clock);
        clear_req = 1'b0;
        for (int k = 0; k < 400 && pa_q.size() == 0; k++) @(negedge clock);
        paint_req = 1'b0;
        repeat (2) @(negedge clock);
        mcells = '0;
        exp_paint(0, 0, 1);
        ca0 = (ca_q.size() > 0) ? ca_q[0] : -1;
        pa0 = (pa_q.size() > 0) ? pa_q[0] : -1;
        tests++;
        if (ca0 != t + 1 + cq.size()) begin
            fails++;
            $display("FAIL prio_clear_ack: got cycle %0d, need %0d", ca0, t + 1 + cq.size());
        end
        tests++;
        if (pq.size() != cq.size() + eq.size()) begin
            fails++;
            $display("FAIL prio_count: got %0d plots, need %0d", pq.size(), cq.size() + eq.size());
        end
        bad = -1;
        for (int j = 0; j < cq.size(); j++) begin
            if (j >= pq.size() || pq[j].x != cq[j].x || pq[j].y != cq[j].y ||
                pq[j].c != cq[j].c || pq[j].t != t + 1 + j) begin
                bad = j;
                break;
            end
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL prio_clear_scan: pixel %0d wrong, need (%0d,%0d)", bad, cq[bad].x, cq[bad].y);
        end
        n0 = cq.size();
        bad = (pq.size() > n0 && pq[n0].t > ca0) ? -1 : 0;
        for (int j = 0; j < eq.size() && bad < 0; j++) begin
            if (n0 + j >= pq.size() || pq[n0+j].x != eq[j].x || pq[n0+j].y != eq[j].y ||
                pq[n0+j].c != eq[j].c || pq[n0+j].t != pq[n0].t + j) begin
                bad = j;
            end
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL prio_paint_scan: pixel %0d wrong, need (%0d,%0d) after clear_ack",
                     bad, eq[bad].x, eq[bad].y);
        end
        tests++;
        if (pq.size() <= n0 || pa0 != pq[n0].t + eq.size()) begin
            fails++;
            $display("FAIL prio_paint_ack: got cycle %0d, need %0d after first paint plot",
                     pa0, eq.size());
        end
        mcells[0] = 1'b1;
        tests++;
        if (cells !== mcells) begin
            fails++;
            $display("FAIL prio_cells: got %h, need %h", cells, mcells);
        end
    endtask

    task automatic test_back_to_back();
        pix_t ea[$];
        int   t;
        int   s;
        int   bad;
        int   va;
        int   vb;
        va = mcells[5*COLS+5] ? 0 : 1;
        exp_paint(5, 5, va);
        ea = eq;
        mcells[5*COLS+5] = va[0];
        vb = mcells[7*COLS+6] ? 0 : 1;
        exp_paint(6, 7, vb);
        mcells[7*COLS+6] = vb[0];
        pq.delete();
        pa_q.delete();
        t = cyc + 1;
        paint_col = 4'd5;
        paint_row = 4'd5;
        paint_val = va[0];
        paint_req = 1'b1;
        for (int k = 0; k < 400 && pa_q.size() == 0; k++) @(negedge clock);
        paint_col = 4'd6;
        paint_row = 4'd7;
        paint_val = vb[0];
        for (int k = 0; k < 400 && pa_q.size() < 2; k++) @(negedge clock);
        paint_req = 1'b0;
        repeat (2) @(negedge clock);
        tests++;
        if (pq.size() != 280 || pa_q.size() != 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d plots %0d acks, need 280 and 2", pq.size(), pa_q.size());
        end
        bad = -1;
        for (int j = 0; j < 140; j++) begin
            if (j >= pq.size() || pq[j].x != ea[j].x || pq[j].y != ea[j].y ||
                pq[j].c != ea[j].c || pq[j].t != t + 1 + j) begin
                bad = j;
                break;
            end
        end
        tests++;
        if (bad >= 0 || pa_q.size() < 1 || pa_q[0] != t + 141) begin
            fails++;
            $display("FAIL b2b_first: bad pixel %0d or ack not at %0d", bad, t + 141);
        end
        s = (pq.size() > 140) ? pq[140].t : -1;
        bad = -1;
        for (int j = 0; j < 140; j++) begin
            if (140 + j >= pq.size() || pq[140+j].x != eq[j].x || pq[140+j].y != eq[j].y ||
                pq[140+j].c != eq[j].c || pq[140+j].t != s + j) begin
                bad = j;
                break;
            end
        end
        tests++;
        if (bad >= 0 || pa_q.size() < 2 || pa_q[1] != s + 140) begin
            fails++;
            $display("FAIL b2b_second: bad pixel %0d or ack not %0d after start %0d", bad, 140, s);
        end
        tests++;
        if (pa_q.size() < 1 || s < pa_q[0] + 2) begin
            fails++;
            $display("FAIL b2b_gap: second plot at %0d, need >= ack+2", s);
        end
        tests++;
        if (cells !== mcells) begin
            fails++;
            $display("FAIL b2b_cells: got %h, need %h", cells, mcells);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int v;
        int ca0;
        v = mcells[4*COLS+7] ? 0 : 1;
        pq.delete();
        pa_q.delete();
        ca_q.delete();
        paint_col = 4'd7;
        paint_row = 4'd4;
        paint_val = v[0];
        paint_req = 1'b1;
        for (int k = 0; k < 400 && pq.size() < 70; k++) @(negedge clock);
        resetn = 1'b0;
        paint_req = 1'b0;
        #1;
        tests++;
        if (pq.size() != 70 || plot !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort: plots %0d plot=%b busy=%b, need 70 0 1", pq.size(), plot, busy);
        end
        repeat (3) @(negedge clock);
        pq.delete();
        t = cyc;
        resetn = 1'b1;
        mcells = '0;
        for (int k = 0; k < 26000 && ca_q.size() == 0; k++) @(negedge clock);
        @(negedge clock);
        ca0 = (ca_q.size() > 0) ? ca_q[0] : -1;
        tests++;
        if (pa_q.size() != 0) begin
            fails++;
            $display("FAIL abort_no_ack: got %0d paint acks, need 0", pa_q.size());
        end
        tests++;
        if (pq.size() != cq.size() || ca0 != t + 1 + cq.size()) begin
            fails++;
            $display("FAIL abort_clear: %0d plots ack %0d, need %0d plots ack %0d",
                     pq.size(), ca0, cq.size(), t + 1 + cq.size());
        end
        tests++;
        if (cells !== mcells || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_cells: got %h busy=%b, need 0 and 0", cells, busy);
        end
    endtask

    task automatic test_invariant();
        tests++;
        if (viol != 0) begin
            fails++;
            $display("FAIL plot_outside_scan: got %0d bad cycles, need 0", viol);
        end
    endtask

    initial begin
        build_clear();
        test_reset();
        test_paint();
        test_invalid();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        test_invariant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
